// File: rtl/uart_tx_fifo.sv
// Purpose: byte FIFO from the CPU UART data register to the transmitter; single-byte pops via start/busy handshake.
// Latency: a byte written into an empty idle FIFO at edge k pops at edge k+1; tx_start is high for the cycle after that edge.
// Backpressure: the transmitter holds tx_busy to stall pops; writes to a full FIFO are dropped and set sticky overflow.
//
// Ports:
//   clk       system clock, all state on rising edge
//   reset     asynchronous active-low reset
//   wr_en     CPU write strobe, one byte pushed per cycle high
//   wr_data   byte to push
//   flush     synchronous clear of queued bytes and overflow
//   tx_busy   transmitter busy level
//   tx_start  registered one-cycle pulse; transmitter latches tx_data
//   tx_data   registered byte presented to transmitter, held until next pop
//   full      count == DEPTH
//   empty     count == 0
//   count     entries stored (0..DEPTH)
//   overflow  sticky flag: a write was dropped
module uart_tx_fifo #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  flush,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  full,
    output logic                  empty,
    output logic [PTR_W:0]        count,
    output logic                  overflow
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_acc;
    logic                  pop;

    // Status flags come straight from the count register, so no input
    // reaches an output combinationally.
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // full/empty here are the pre-edge values; flush beats both push and pop.
    assign wr_acc = wr_en & ~full & ~flush;
    assign pop    = (state == S_IDLE) & ~empty & ~tx_busy & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Flush does not touch the handshake: an in-flight byte still walks
    // WAIT_BUSY -> WAIT_DONE so the transmitter and FSM stay in step.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (pop)      state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: if (tx_busy)  state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (!tx_busy) state_nxt = S_IDLE;
            default:                   state_nxt = S_IDLE;
        endcase
    end

    // Storage needs no reset; only entries between the pointers are read.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_start <= pop;
            if (pop) begin
                tx_data <= mem[rd_ptr];
            end
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (wr_acc && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !wr_acc) begin
                    count <= count - 1'b1;
                end
                // A dropped write is flagged even if a pop frees a slot this edge.
                if (wr_en && full) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: queue of stored bytes plus a "byte handed to the
    // transmitter and not yet finished" flag.
    logic [7:0] q[$];
    logic [7:0] m_txd;
    bit         m_over, m_txs, in_flight, seen_busy;

    // Transmitter stand-in driving tx_busy.
    bit          tx_b, pend, hold_busy;
    int unsigned dly, len, len_lo, len_hi;

    logic [7:0] rx_log[$];
    int         peak;
    logic [7:0] msg [7];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_txd = 8'h00; m_over = 0; m_txs = 0; in_flight = 0; seen_busy = 0;
        tx_b = 0; pend = 0; hold_busy = 0; dly = 0; len = 0;
        tx_busy = 1'b0;
    endtask

    // One clock: drive inputs at the falling edge, update the model at the
    // rising edge, compare at the next falling edge, then move the transmitter.
    task automatic step(input bit we, input logic [7:0] wd, input bit fl);
        bit pre_full, do_pop;
        wr_en = we; wr_data = wd; flush = fl;
        @(posedge clk);
        pre_full = (q.size() == DEPTH);
        do_pop   = !in_flight && (q.size() != 0) && !tx_busy && !fl;
        if (fl) begin
            q.delete();
            m_over = 0;
        end else begin
            if (do_pop) m_txd = q.pop_front();
            if (we && !pre_full) q.push_back(wd);
            if (we && pre_full) m_over = 1;
        end
        if (do_pop) begin
            in_flight = 1; seen_busy = 0;
        end else if (in_flight && !seen_busy && tx_busy) begin
            seen_busy = 1;
        end else if (in_flight && seen_busy && !tx_busy) begin
            in_flight = 0;
        end
        m_txs = do_pop;
        @(negedge clk);
        chk("count",    32'(count),    32'(q.size()));
        chk("empty",    32'(empty),    32'(q.size() == 0));
        chk("full",     32'(full),     32'(q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_over));
        chk("tx_start", 32'(tx_start), 32'(m_txs));
        chk("tx_data",  32'(tx_data),  32'(m_txd));
        if (tx_start === 1'b1) rx_log.push_back(tx_data);
        if (int'(count) > peak) peak = int'(count);
        if (m_txs) begin
            pend = 1;
            dly  = $urandom_range(0, 2);
            len  = $urandom_range(len_lo, len_hi);
        end
        if (pend) begin
            if (dly == 0) begin tx_b = 1; pend = 0; end
            else dly--;
        end else if (tx_b) begin
            if (len <= 1) tx_b = 0;
            else len--;
        end
        tx_busy = tx_b | hold_busy;
    endtask

    task automatic drain(input int max);
        bit done;
        done = 0;
        for (int i = 0; i < max && !done; i++) begin
            step(0, 8'h00, 0);
            done = !in_flight && (q.size() == 0) && !pend && !tx_b;
        end
        chk("drain_done", 32'(done), 32'd1);
    endtask

    task automatic chk_reset_values(input string pfx);
        chk({pfx, "_empty"},    32'(empty),    32'd1);
        chk({pfx, "_full"},     32'(full),     32'd0);
        chk({pfx, "_count"},    32'(count),    32'd0);
        chk({pfx, "_overflow"}, 32'(overflow), 32'd0);
        chk({pfx, "_tx_start"}, 32'(tx_start), 32'd0);
        chk({pfx, "_tx_data"},  32'(tx_data),  32'h00);
    endtask

    initial begin
        msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};
        len_lo = 1; len_hi = 5; peak = 0;
        reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
        model_clear();

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_values("rst");
        reset = 1'b1;

        // Single byte: pulse one cycle after the push edge
        rx_log.delete();
        step(1, 8'h41, 0);
        chk("t2_no_start_yet", 32'(tx_start), 32'd0);
        step(0, 8'h00, 0);
        chk("t2_start", 32'(tx_start), 32'd1);
        chk("t2_data",  32'(tx_data),  32'h41);
        step(0, 8'h00, 0);
        chk("t2_start_low", 32'(tx_start), 32'd0);
        drain(100);
        chk("t2_rx_n", 32'(rx_log.size()), 32'd1);
        if (rx_log.size() > 0) chk("t2_rx0", 32'(rx_log[0]), 32'h41);

        // Burst "Hello\r\n" against a slow transmitter
        len_lo = 12; len_hi = 15; peak = 0; rx_log.delete();
        for (int i = 0; i < 7; i++) step(1, msg[i], 0);
        drain(400);
        chk("t3_peak", 32'(peak), 32'd6);
        chk("t3_rx_n", 32'(rx_log.size()), 32'd7);
        for (int i = 0; i < 7 && i < rx_log.size(); i++)
            chk("t3_rx", 32'(rx_log[i]), 32'(msg[i]));
        chk("t3_empty", 32'(empty), 32'd1);

        // Overflow with the transmitter held busy
        len_lo = 1; len_hi = 5; rx_log.delete();
        hold_busy = 1; tx_busy = 1'b1;
        for (int i = 0; i <= DEPTH; i++) step(1, 8'(i), 0);
        chk("t4_full",     32'(full),     32'd1);
        chk("t4_count",    32'(count),    32'd16);
        chk("t4_overflow", 32'(overflow), 32'd1);
        hold_busy = 0; tx_busy = tx_b;
        drain(600);
        chk("t4_rx_n", 32'(rx_log.size()), 32'd16);
        for (int i = 0; i < rx_log.size(); i++)
            chk("t4_rx", 32'(rx_log[i]), 32'(i));
        chk("t4_overflow_sticky", 32'(overflow), 32'd1);

        // Pointer wrap: 10 + 10 bytes
        rx_log.delete();
        for (int i = 0; i < 10; i++) step(1, 8'hA0 + 8'(i), 0);
        drain(400);
        for (int i = 0; i < 10; i++) step(1, 8'hB0 + 8'(i), 0);
        drain(400);
        chk("t5_rx_n", 32'(rx_log.size()), 32'd20);
        for (int i = 0; i < 20 && i < rx_log.size(); i++)
            chk("t5_rx", 32'(rx_log[i]), (i < 10) ? 32'(8'hA0 + 8'(i)) : 32'(8'hB0 + 8'(i - 10)));

        // Flush during WAIT_DONE with 5 queued; same-cycle write ignored
        len_lo = 20; len_hi = 25; rx_log.delete();
        for (int i = 0; i < 6; i++) step(1, 8'hC0 + 8'(i), 0);
        for (int i = 0; i < 50 && !(in_flight && seen_busy); i++) step(0, 8'h00, 0);
        chk("t6_in_wait_done", 32'(in_flight && seen_busy), 32'd1);
        chk("t6_count5", 32'(count), 32'd5);
        step(1, 8'hEE, 1);
        chk("t6_count0",    32'(count),    32'd0);
        chk("t6_overflow0", 32'(overflow), 32'd0);
        drain(200);
        chk("t6_rx_n",  32'(rx_log.size()), 32'd1);
        if (rx_log.size() > 0) chk("t6_rx0", 32'(rx_log[0]), 32'hC0);

        // Randomised traffic with occasional flushes and busy stalls
        len_lo = 1; len_hi = 6;
        for (int i = 0; i < 600; i++) begin
            hold_busy = ((i % 200) >= 150);
            tx_busy   = tx_b | hold_busy;
            step(bit'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 59) == 0));
        end
        hold_busy = 0; tx_busy = tx_b;
        drain(800);

        // Asynchronous reset while waiting for busy
        len_lo = 10; len_hi = 12;
        step(1, 8'hD0, 0);
        step(1, 8'hD1, 0);
        chk("t7_start", 32'(tx_start), 32'd1);
        step(1, 8'hD2, 0);
        #1;
        reset = 1'b0;
        #1;
        chk_reset_values("t7_rst");
        model_clear();
        wr_en = 1'b0; flush = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        rx_log.delete();
        drain(50);
        chk("t7_no_tx", 32'(rx_log.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
